// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX ingest path: the FIFO word width
// and the SOH field delimiter byte.
package fix_pkg;
  localparam int         FIFO_DW  = 32;
  localparam logic [7:0] SOH_CHAR = 8'h01;

  typedef logic [7:0] fix_byte_t;
endpackage

// File: rtl/word_skid_buf.sv
// Two-entry word buffer (head/tail). Slot 0 is always the oldest word, and
// a push in the same cycle as a pop lands in the slot left free after the shift.
module word_skid_buf
  import fix_pkg::FIFO_DW;
#(
  parameter int W = FIFO_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] tail;
  logic [1:0]   base;

  // Occupancy seen by the incoming word once this cycle's pop has shifted.
  assign base = occ - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (clr) begin
      occ <= '0;
    end else begin
      if (pop)                   head <= tail;
      if (push && base == 2'd0)  head <= din;
      if (push && base == 2'd1)  tail <= din;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/fifo_byte_reader.sv
// FIFO read-side consumer: pops 32-bit words, absorbs the RAM read latency
// and streams them out MSB byte first with SOH tagging.
module fifo_byte_reader
  import fix_pkg::fix_byte_t;
  import fix_pkg::FIFO_DW;
#(
  parameter int        DATA_WIDTH = FIFO_DW,
  parameter int        BYTES      = DATA_WIDTH / 8,
  parameter fix_byte_t SOH_CHAR   = fix_pkg::SOH_CHAR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_cs_o,
  output logic                  fifo_rd_en_o,
  input  logic                  flush_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  soh_o,
  output logic [15:0]           word_cnt_o
);
  localparam int             IW      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0]  IDX_TOP = IW'(BYTES - 1);

  logic                  rd_inflight;
  logic [IW-1:0]         idx;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  capture;
  logic                  accept;
  logic                  retire;
  fix_byte_t             lane;

  // One read in flight at most, so reads are never back-to-back and the
  // lagging FIFO empty flag can never cause an underflow.
  assign fifo_rd_en_o = !rst && !fifo_empty_i && !rd_inflight && !flush_i &&
                        ((occ + {1'b0, rd_inflight}) < 2'd2);
  assign fifo_rd_cs_o = fifo_rd_en_o;

  assign capture      = rd_inflight && !flush_i;
  assign byte_valid_o = (occ != 2'd0);
  assign accept       = byte_valid_o && byte_ready_i && !flush_i;
  assign retire       = accept && (idx == '0);

  assign lane   = head[8*idx +: 8];
  assign byte_o = byte_valid_o ? lane : 8'h00;
  assign soh_o  = byte_valid_o && (byte_o == SOH_CHAR);

  word_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush_i),
    .push (capture),
    .din  (fifo_data_i),
    .pop  (retire),
    .head (head),
    .occ  (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      idx         <= IDX_TOP;
      word_cnt_o  <= '0;
    end else begin
      // A flush suppresses the read strobe, so this also drops the pending return.
      rd_inflight <= fifo_rd_en_o;
      if (flush_i) begin
        idx        <= IDX_TOP;
        word_cnt_o <= '0;
      end else begin
        if (capture) word_cnt_o <= word_cnt_o + 16'd1;
        if (accept)  idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_byte_reader.sv
// Scoreboard bench: a FIFO model feeds the reader, every pop queues the
// expected MSB-first bytes, and a negedge monitor checks what comes out.
module tb_fifo_byte_reader;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_cs, fifo_rd_en;
  logic          flush = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready = 1'b1;
  logic          soh;
  logic [15:0]   word_cnt;

  fifo_byte_reader dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_cs_o (fifo_rd_cs),
    .fifo_rd_en_o (fifo_rd_en),
    .flush_i      (flush),
    .byte_o       (byte_out),
    .byte_valid_o (byte_valid),
    .byte_ready_i (byte_ready),
    .soh_o        (soh),
    .word_cnt_o   (word_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          words_popped = 0;
  int          bytes_done = 0;
  logic        prev_rd = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [7:0]  prev_byte = '0;
  logic [DW-1:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int          acc_cyc[$];
  int          strobe_cyc[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a pop returns its word one cycle later; the expected byte
  // stream is the popped word, most significant byte first.
  always @(posedge clk) begin
    if (!rst) begin
      if (flush) begin
        exp_q.delete();
        words_popped = 0;
        bytes_done   = 0;
      end
      if (fifo_rd_en) begin
        check("rd_cs_with_en", fifo_rd_cs, 1'b1);
        check("rd_not_empty", fifo_q.size() != 0, 1'b1);
        check("rd_not_b2b", prev_rd, 1'b0);
        check("rd_not_in_flush", flush, 1'b0);
        if (fifo_q.size() != 0) begin
          logic [DW-1:0] w;
          w = fifo_q.pop_front();
          fifo_data <= w;
          for (int i = NB - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
          words_popped++;
        end
      end
      prev_rd <= fifo_rd_en;
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush)
        check("stall_hold", {byte_valid, byte_out}, {1'b1, prev_byte});
      if (!byte_valid) begin
        check("idle_outputs_zero", {soh, byte_out}, 9'h0);
      end else if (byte_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {1'b1, byte_out}, 9'h0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte", byte_out, e);
          check("soh", soh, e == 8'h01);
          acc_cyc.push_back(cyc);
          bytes_done++;
        end
      end
      if (fifo_rd_en) strobe_cyc.push_back(cyc);
      check("held_words_le2", (words_popped - bytes_done / NB) <= 2, 1'b1);
      prev_stall = byte_valid && !byte_ready;
      prev_flush = flush;
      prev_byte  = byte_out;
    end
  end

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      int            ln;
      w = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        ln = $urandom_range(0, NB - 1);
        w[ln*8 +: 8] = 8'h01;
      end
      fifo_q.push_back(w);
    end
  endtask

  task automatic wait_bytes(input string name, input int target, input int budget);
    for (int i = 0; i < budget && bytes_done < target; i++) begin
      @(negedge clk); #1;
    end
    check(name, bytes_done >= target, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int budget, input logic rand_ready);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      if (rand_ready) byte_ready = ($urandom_range(0, 2) != 0);
      n++;
    end
    byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(name, (fifo_q.size() == 0) && (exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int n;
    int wp;
    logic ok;

    // 1: reset state, then idle with an empty FIFO
    #3;
    check("reset_outputs", {fifo_rd_en, fifo_rd_cs, byte_valid, byte_out, soh, word_cnt}, '0);
    @(negedge clk); rst = 1'b0;
    repeat (16) begin
      @(negedge clk); #1;
      check("idle_empty", {fifo_rd_en, fifo_rd_cs, byte_valid, byte_out, soh, word_cnt}, '0);
    end

    // 2: single word, latency and SOH on the last byte
    acc_cyc.delete(); strobe_cyc.delete();
    b0 = bytes_done;
    fifo_q.push_back(32'h383D_4601);
    wait_bytes("t2_bytes", b0 + 4, 40);
    check("t2_one_strobe", strobe_cyc.size(), 1);
    if (strobe_cyc.size() >= 1 && acc_cyc.size() >= 4)
      for (int i = 0; i < 4; i++) check("t2_latency", acc_cyc[i], strobe_cyc[0] + 2 + i);
    @(posedge clk); #1;
    check("t2_word_cnt", word_cnt, 16'd1);

    // 3: eight words streamed, no gaps after the first byte
    acc_cyc.delete();
    b0 = bytes_done;
    push_words(8);
    wait_bytes("t3_bytes", b0 + 32, 200);
    ok = (acc_cyc.size() >= 32);
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] != acc_cyc[i-1] + 1) ok = 1'b0;
    check("t3_no_gaps", ok, 1'b1);
    @(posedge clk); #1;
    check("t3_word_cnt", word_cnt, 16'd9);

    // 4: backpressure mid-word, then random ready
    b0 = bytes_done;
    push_words(6);
    wait_bytes("t4_prime", b0 + 2, 40);
    @(posedge clk); #1 byte_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t4_stall_pops", (words_popped - bytes_done / NB) <= 2, 1'b1);
    byte_ready = 1'b1;
    push_words(6);
    wait_drain("t4_drain", 600, 1'b1);
    check("t4_word_cnt", word_cnt, 16'(words_popped));

    // 5: flush in the cycle after a read strobe
    fifo_q.push_back($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!fifo_rd_en && n < 20);
    check("t5_strobe_seen", fifo_rd_en, 1'b1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("t5_valid_dropped", byte_valid, 1'b0);
    check("t5_word_cnt_zero", word_cnt, 16'd0);
    @(negedge clk);
    check("t5_still_empty", byte_valid, 1'b0);
    push_words(2);
    wait_drain("t5_drain", 100, 1'b0);
    check("t5_word_cnt_after", word_cnt, 16'd2);

    // 6: asynchronous reset pulse between clock edges mid-stream
    b0 = bytes_done;
    push_words(8);
    wait_bytes("t6_prime", b0 + 6, 60);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("t6_async_clear", {fifo_rd_en, fifo_rd_cs, byte_valid, byte_out, soh, word_cnt}, '0);
    exp_q.delete();
    words_popped = 0;
    bytes_done   = 0;
    prev_rd      = 1'b0;
    #1 rst = 1'b0;
    wp = fifo_q.size();
    wait_drain("t6_drain", 200, 1'b0);
    check("t6_word_cnt", word_cnt, 16'(wp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
